// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU codes, FSM states, trap causes and legality check for the RV32I controller
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [3:0] {
    CC_AND = 4'b0000, CC_OR  = 4'b0001, CC_ADD = 4'b0010, CC_XOR = 4'b0011,
    CC_SLL = 4'b0100, CC_SRL = 4'b0101, CC_SUB = 4'b0110, CC_SRA = 4'b0111,
    CC_LT  = 4'b1000, CC_LTU = 4'b1001, CC_EQ  = 4'b1010, CC_NE  = 4'b1011,
    CC_GE  = 4'b1100, CC_GEU = 4'b1101
  } alu_cc_e;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_TRAP} state_e;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_DMEM, CAUSE_IMEM} cause_e;
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    case (op)
      OP_R:      return f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      OP_IMM:    return f3 == 3'b001 ? f7 == 7'b0 :
                        f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
      OP_LOAD:   return f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111;
      OP_STORE:  return f3 <= 3'b010;
      OP_BRANCH: return f3 != 3'b010 && f3 != 3'b011;
      OP_JALR:   return f3 == 3'b000;
      OP_JAL, OP_LUI, OP_AUIPC: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps opcode/funct3/funct7[5] to the ALU operation code
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_cc_e    alu_cc
);
  logic arith, alt;
  assign arith = opcode == OP_R || opcode == OP_IMM;
  // immediates reuse funct7 bits as data, so only SRAI honours bit 5
  assign alt = funct7_5 && (opcode == OP_R || funct3 == 3'b101);
  always_comb begin
    alu_cc = CC_ADD;
    if (arith)
      case (funct3)
        3'b000:  alu_cc = alt ? CC_SUB : CC_ADD;
        3'b001:  alu_cc = CC_SLL;
        3'b010:  alu_cc = CC_LT;
        3'b011:  alu_cc = CC_LTU;
        3'b100:  alu_cc = CC_XOR;
        3'b101:  alu_cc = alt ? CC_SRA : CC_SRL;
        3'b110:  alu_cc = CC_OR;
        default: alu_cc = CC_AND;
      endcase
    else if (opcode == OP_BRANCH)
      case (funct3)
        3'b001:  alu_cc = CC_NE;
        3'b100:  alu_cc = CC_LT;
        3'b101:  alu_cc = CC_GE;
        3'b110:  alu_cc = CC_LTU;
        3'b111:  alu_cc = CC_GEU;
        default: alu_cc = CC_EQ;
      endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/exec/mem sequencer for the RV32I datapath with
// ready handshakes, timeouts, sticky trap and retired-instruction counter
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int ALU_CC_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic [2:0]          Funct3,
  input  logic [6:0]          Funct7,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                Jal,
  output logic                Jalr,
  output logic                Branch,
  output logic                ALUsrcA,
  output logic                ALUsrcB,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [1:0]          writeSelect,
  output logic [ALU_CC_W-1:0] ALU_CC,
  output logic                retire,
  output logic [31:0]         instret,
  output logic                trap,
  output logic [1:0]          trap_cause
);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_e state;
  cause_e cause;
  alu_cc_e cc;
  logic [7:0] cnt;
  logic in_f, in_d, in_e, in_m, is_load, is_store, is_mem, mem_done;
  alu_decoder u_dec (.opcode(opcode), .funct3(Funct3), .funct7_5(Funct7[5]), .alu_cc(cc));
  // strobes are gated by reset so they drop asynchronously with it
  assign in_f = !reset && state == S_FETCH;
  assign in_d = !reset && state == S_DECODE;
  assign in_e = !reset && state == S_EXEC;
  assign in_m = !reset && state == S_MEM;
  assign is_load  = opcode == OP_LOAD;
  assign is_store = opcode == OP_STORE;
  assign is_mem   = is_load || is_store;
  assign mem_done = in_m && dmem_ready;
  assign imem_req = in_f;
  assign IRWrite  = in_f && imem_ready;
  assign retire   = (in_e && !is_mem) || mem_done;
  assign PCWrite  = retire;
  assign Jal      = in_e && opcode == OP_JAL;
  assign Jalr     = in_e && opcode == OP_JALR;
  assign Branch   = in_e && opcode == OP_BRANCH;
  assign ALUsrcA  = 1'b0;
  assign ALUsrcB  = in_m || (in_e && (opcode == OP_IMM || opcode == OP_JALR || is_mem));
  assign RegWrite = (mem_done && is_load) || (in_e && (opcode == OP_R || opcode == OP_IMM ||
                    opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL || opcode == OP_JALR));
  assign MemtoReg = mem_done && is_load;
  assign MemRead  = in_m && is_load;
  assign MemWrite = in_m && is_store;
  assign writeSelect = !in_e ? 2'b00 :
                       opcode == OP_LUI ? 2'b10 :
                       opcode == OP_AUIPC ? 2'b11 :
                       (opcode == OP_JAL || opcode == OP_JALR) ? 2'b01 : 2'b00;
  assign ALU_CC = (in_e || in_m) ? ALU_CC_W'(cc) : '0;
  assign trap = state == S_TRAP;
  assign trap_cause = cause;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= S_FETCH;
      cause   <= CAUSE_NONE;
      cnt     <= '0;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + 32'd1;
      case (state)
        S_FETCH:
          if (imem_ready) state <= S_DECODE;
          else if (cnt == TO) begin
            state <= S_TRAP;
            cause <= CAUSE_IMEM;
          end else cnt <= cnt + 8'd1;
        S_DECODE: begin
          cnt <= '0;
          if (in_d && is_legal(opcode, Funct3, Funct7)) state <= S_EXEC;
          else begin
            state <= S_TRAP;
            cause <= CAUSE_ILLEGAL;
          end
        end
        S_EXEC: begin
          cnt   <= '0;
          state <= is_mem ? S_MEM : S_FETCH;
        end
        S_MEM:
          if (dmem_ready) begin
            state <= S_FETCH;
            cnt   <= '0;
          end else if (cnt == TO) begin
            state <= S_TRAP;
            cause <= CAUSE_DMEM;
          end else cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
endmodule
